car_lane_controller: RTL and testbench
======================================

// Module: car_lane_controller
// PURPOSE
//  Upstream stage of the sprite display. Generates one car's top-left position
//  for its lane, advancing it on frame ticks with horizontal wrap-around.
//  Detects AABB overlap with the frog and freezes the lane for a hit penalty.
//  Drives the display's Car_X/Car_Y inputs and the game controller's collision input.
// PARAMETERS
//  TILE_SIZE            32   sprite edge, pixels (car and frog)
//  H_VISIBLE_AREA       640  visible width, pixels
//  LANE_Y               224  fixed car Y (top-left), pixels
//  DIRECTION            0    0 = left-to-right, 1 = right-to-left
//  START_X              0    spawn X; must be <= H_VISIBLE_AREA-TILE_SIZE
//  STEP_PIXELS          4    pixels moved per step, 1..TILE_SIZE
//  BASE_FRAMES_PER_STEP 8    frames per step at level 0 (power of 2)
//  MAX_LEVEL            3    highest speed level
//  HIT_FREEZE_FRAMES    60   frames held in HIT before respawn
// PORTS
//  i_Clk            in   1   pixel clock (25 MHz)
//  i_Rst            in   1   synchronous reset, active-high
//  i_Frame_Tick     in   1   1-cycle pulse per frame, at start of vertical blanking
//  i_Start          in   1   1-cycle pulse: IDLE -> RUN
//  i_Stop           in   1   1-cycle pulse: any state -> IDLE
//  i_Level_Up       in   1   1-cycle pulse: speed level +1, saturating
//  i_Frog_X_Position in  10  frog top-left X
//  i_Frog_Y_Position in  10  frog top-left Y
//  o_Car_X_Position out  10  car top-left X, registered
//  o_Car_Y_Position out  10  car top-left Y, constant LANE_Y
//  o_Collision      out  1   1-cycle pulse on detected hit
//  o_Running        out  1   high while state == RUN
//  o_Level          out  2   current speed level
// BEHAVIOUR
//  Reset: state IDLE, X = START_X, o_Collision = 0, o_Running = 0, o_Level = 0,
//    frame and freeze counters = 0.
//  States: IDLE, RUN, HIT. Priority: i_Rst > i_Stop > all other events.
//  IDLE: X held at START_X. On i_Start -> RUN with frame_cnt = 0.
//  RUN: frame ticks only. period = max(1, BASE_FRAMES_PER_STEP >> level).
//  - Collision check: uses registered car X (pre-move) and the current frog
//    inputs. Hit when car_x < frog_x+TILE, frog_x < car_x+TILE, LANE_Y < frog_y+TILE,
//    and frog_y < LANE_Y+TILE. Compare 11 bits wide; no overflow.
//  - On a hit tick: o_Collision = 1 the following cycle, -> HIT, freeze_cnt = 0.
//    There is no move on that tick. A hit takes priority over a move.
//  - Otherwise, if frame_cnt >= period-1: move and set frame_cnt = 0; else frame_cnt+1.
//    The >= compare absorbs a mid-count level increase.
//  Move, L->R: if X + STEP > H_VISIBLE_AREA-TILE then X = 0, else X + STEP.
//  Move, R->L: if X < STEP then X = H_VISIBLE_AREA-TILE, else X - STEP.
//  HIT: X frozen. Each tick increments freeze_cnt. On the tick where
//    freeze_cnt == HIT_FREEZE_FRAMES-1: -> RUN, X = START_X, frame_cnt = 0.
//    No collision re-check while in HIT.
//  o_Collision is high for exactly one cycle per hit. It is never asserted in IDLE or HIT.
//  Level: i_Level_Up increments o_Level in any state, saturating at MAX_LEVEL.
//    It is cleared only by i_Rst. i_Level_Up together with i_Frame_Tick: the tick uses the old level.
//  i_Stop: -> IDLE and X = START_X next cycle. Overrides a simultaneous hit or i_Start.
//  Reset mid-operation: all state is restored to the reset values on the next edge.
// STRUCTURE
//  Shared header frogger_defs.vh: TILE_SIZE, H_VISIBLE_AREA, V_VISIBLE_AREA,
//    lane state encodings (IDLE=2'd0, RUN=2'd1, HIT=2'd2).
//  Sub-module tile_overlap: combinational AABB test on two TILE-sized boxes.
//    Shared with the sprite display and later lanes.
// TESTING
//  1. Reset, i_Start, 3 ticks at level 0 -> X stays 0; 8th tick -> X = 4.
//  2. DIRECTION=0, X = 604, step tick -> X = 608; next step -> X = 0 (wrap).
//  3. DIRECTION=1, X = 2, step tick -> X = 608.
//  4. Frog (100,224), car X = 80, tick -> o_Collision pulse 1 cycle, X frozen at 80;
//     60 ticks later -> RUN, X = 0.
//  5. 4x i_Level_Up -> o_Level = 3 (saturated), period 1; each tick moves 4 px.
//     Frog at X = 31 vs car X = 0 hits; frog at X = 32 does not.
//  6. i_Stop together with a hitting tick -> IDLE, X = 0, no o_Collision.
//     i_Rst mid-HIT -> IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/car_lane_controller_pkg.sv
// Shared definitions for the car lane: screen geometry, lane state encoding
// and the speed-level to frames-per-step mapping.
package car_lane_controller_pkg;

    localparam int TILE_SIZE      = 32;
    localparam int H_VISIBLE_AREA = 640;

    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_RUN  = 2'd1,
        LANE_HIT  = 2'd2
    } lane_state_t;

    // Each level halves the step period, but a lane never moves more than once per frame.
    function automatic int framesPerStep(input int base, input logic [1:0] level);
        int p;
        p = base >> level;
        if (p < 1) begin
            p = 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/car_lane_controller_tile_overlap.sv
// Combinational AABB overlap test between two TILE-sized square sprites.
// Shared with the sprite display and the other lanes.
module tile_overlap
    import car_lane_controller_pkg::*;
#(
    parameter int TILE = TILE_SIZE
) (
    input  logic [9:0] i_A_X,
    input  logic [9:0] i_A_Y,
    input  logic [9:0] i_B_X,
    input  logic [9:0] i_B_Y,
    output logic       o_Overlap
);

    // Widen by one bit so that position + TILE cannot wrap near the screen edge.
    logic [10:0] w_A_X;
    logic [10:0] w_A_Y;
    logic [10:0] w_B_X;
    logic [10:0] w_B_Y;
    logic [10:0] w_Tile;

    assign w_A_X  = {1'b0, i_A_X};
    assign w_A_Y  = {1'b0, i_A_Y};
    assign w_B_X  = {1'b0, i_B_X};
    assign w_B_Y  = {1'b0, i_B_Y};
    assign w_Tile = 11'(TILE);

    assign o_Overlap = (w_A_X < w_B_X + w_Tile) && (w_B_X < w_A_X + w_Tile) &&
                       (w_A_Y < w_B_Y + w_Tile) && (w_B_Y < w_A_Y + w_Tile);

endmodule

// File: rtl/car_lane_controller.sv
// One car lane: moves the car on frame ticks with wrap-around, detects hits
// against the frog and freezes the lane for a penalty period before respawn.
module car_lane_controller
    import car_lane_controller_pkg::*;
#(
    parameter int LANE_Y               = 224,
    parameter int DIRECTION            = 0,
    parameter int START_X              = 0,
    parameter int STEP_PIXELS          = 4,
    parameter int BASE_FRAMES_PER_STEP = 8,
    parameter int MAX_LEVEL            = 3,
    parameter int HIT_FREEZE_FRAMES    = 60
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Frame_Tick,
    input  logic       i_Start,
    input  logic       i_Stop,
    input  logic       i_Level_Up,
    input  logic [9:0] i_Frog_X_Position,
    input  logic [9:0] i_Frog_Y_Position,
    output logic [9:0] o_Car_X_Position,
    output logic [9:0] o_Car_Y_Position,
    output logic       o_Collision,
    output logic       o_Running,
    output logic [1:0] o_Level
);

    localparam logic [9:0]  LP_START_X   = 10'(START_X);
    localparam logic [9:0]  LP_LANE_Y    = 10'(LANE_Y);
    localparam logic [9:0]  LP_STEP      = 10'(STEP_PIXELS);
    localparam logic [10:0] LP_X_LIMIT   = 11'(H_VISIBLE_AREA - TILE_SIZE);
    localparam logic [1:0]  LP_MAX_LEVEL = 2'(MAX_LEVEL);
    localparam int          FRZ_W        = (HIT_FREEZE_FRAMES > 1) ? $clog2(HIT_FREEZE_FRAMES) : 1;
    localparam logic [FRZ_W-1:0] LP_FRZ_LAST = FRZ_W'(HIT_FREEZE_FRAMES - 1);

    lane_state_t      r_State;
    lane_state_t      w_State_Next;
    logic [9:0]       r_X;
    logic [9:0]       w_X_Next;
    logic [7:0]       r_Frame_Cnt;
    logic [7:0]       w_Frame_Next;
    logic [FRZ_W-1:0] r_Freeze_Cnt;
    logic [FRZ_W-1:0] w_Freeze_Next;
    logic             r_Collision;
    logic             w_Collision_Next;
    logic [1:0]       r_Level;
    logic [1:0]       w_Level_Next;

    logic             w_Hit;
    logic [10:0]      w_X_Sum;
    logic [9:0]       w_Moved_X;
    logic [7:0]       w_Period_Last;

    tile_overlap #(
        .TILE (TILE_SIZE)
    ) u_tile_overlap (
        .i_A_X     (r_X),
        .i_A_Y     (LP_LANE_Y),
        .i_B_X     (i_Frog_X_Position),
        .i_B_Y     (i_Frog_Y_Position),
        .o_Overlap (w_Hit)
    );

    assign w_X_Sum       = {1'b0, r_X} + {1'b0, LP_STEP};
    assign w_Period_Last = 8'(framesPerStep(BASE_FRAMES_PER_STEP, r_Level) - 1);

    always_comb begin
        w_Moved_X = r_X;
        if (DIRECTION == 0) begin
            w_Moved_X = (w_X_Sum > LP_X_LIMIT) ? 10'd0 : w_X_Sum[9:0];
        end else begin
            w_Moved_X = (r_X < LP_STEP) ? LP_X_LIMIT[9:0] : (r_X - LP_STEP);
        end
    end

    always_comb begin
        w_State_Next     = r_State;
        w_X_Next         = r_X;
        w_Frame_Next     = r_Frame_Cnt;
        w_Freeze_Next    = r_Freeze_Cnt;
        w_Collision_Next = 1'b0;
        w_Level_Next     = (i_Level_Up && (r_Level != LP_MAX_LEVEL)) ? (r_Level + 2'd1) : r_Level;

        if (i_Stop) begin
            w_State_Next  = LANE_IDLE;
            w_X_Next      = LP_START_X;
            w_Frame_Next  = 8'd0;
            w_Freeze_Next = '0;
        end else begin
            case (r_State)
                LANE_IDLE: begin
                    w_X_Next = LP_START_X;
                    if (i_Start) begin
                        w_State_Next = LANE_RUN;
                        w_Frame_Next = 8'd0;
                    end
                end
                LANE_RUN: begin
                    // A hit on this tick suppresses the move so the car freezes where it was hit.
                    if (i_Frame_Tick) begin
                        if (w_Hit) begin
                            w_State_Next     = LANE_HIT;
                            w_Freeze_Next    = '0;
                            w_Collision_Next = 1'b1;
                        end else if (r_Frame_Cnt >= w_Period_Last) begin
                            w_X_Next     = w_Moved_X;
                            w_Frame_Next = 8'd0;
                        end else begin
                            w_Frame_Next = r_Frame_Cnt + 8'd1;
                        end
                    end
                end
                LANE_HIT: begin
                    if (i_Frame_Tick) begin
                        if (r_Freeze_Cnt == LP_FRZ_LAST) begin
                            w_State_Next = LANE_RUN;
                            w_X_Next     = LP_START_X;
                            w_Frame_Next = 8'd0;
                        end else begin
                            w_Freeze_Next = r_Freeze_Cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_State_Next = LANE_IDLE;
                    w_X_Next     = LP_START_X;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State      <= LANE_IDLE;
            r_X          <= LP_START_X;
            r_Frame_Cnt  <= 8'd0;
            r_Freeze_Cnt <= '0;
            r_Collision  <= 1'b0;
            r_Level      <= 2'd0;
        end else begin
            r_State      <= w_State_Next;
            r_X          <= w_X_Next;
            r_Frame_Cnt  <= w_Frame_Next;
            r_Freeze_Cnt <= w_Freeze_Next;
            r_Collision  <= w_Collision_Next;
            r_Level      <= w_Level_Next;
        end
    end

    assign o_Car_X_Position = r_X;
    assign o_Car_Y_Position = LP_LANE_Y;
    assign o_Collision      = r_Collision;
    assign o_Running        = (r_State == LANE_RUN);
    assign o_Level          = r_Level;

endmodule

// File: tb/tb_car_lane_controller.sv
// Bench for car_lane_controller: one lane per direction driven in parallel,
// checked every cycle against a behavioural lane model plus directed literals.
module tb_car_lane_controller;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       start;
    logic       stop;
    logic       lvlUp;
    logic [9:0] frogX;
    logic [9:0] frogY;

    logic [9:0] lrX, lrY, rlX, rlY;
    logic       lrColl, lrRun, rlColl, rlRun;
    logic [1:0] lrLvl, rlLvl;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    // Model state per lane (0 = left-to-right, 1 = right-to-left): mode 0 idle, 1 run, 2 hit.
    int mMode[2];
    int mX[2];
    int mFrames[2];
    int mFrozen[2];
    int mColl[2];
    int mLevel;

    car_lane_controller #(.DIRECTION(0)) dutLr (
        .i_Clk(clk), .i_Rst(rst), .i_Frame_Tick(tick), .i_Start(start), .i_Stop(stop),
        .i_Level_Up(lvlUp), .i_Frog_X_Position(frogX), .i_Frog_Y_Position(frogY),
        .o_Car_X_Position(lrX), .o_Car_Y_Position(lrY), .o_Collision(lrColl),
        .o_Running(lrRun), .o_Level(lrLvl)
    );

    car_lane_controller #(.DIRECTION(1)) dutRl (
        .i_Clk(clk), .i_Rst(rst), .i_Frame_Tick(tick), .i_Start(start), .i_Stop(stop),
        .i_Level_Up(lvlUp), .i_Frog_X_Position(frogX), .i_Frog_Y_Position(frogY),
        .o_Car_X_Position(rlX), .o_Car_Y_Position(rlY), .o_Collision(rlColl),
        .o_Running(rlRun), .o_Level(rlLvl)
    );

    initial clk = 0;
    always #20 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int movedX(input int dir, input int x);
        if (dir == 0) return (x + 4 > 608) ? 0 : x + 4;
        return (x < 4) ? 608 : x - 4;
    endfunction

    function automatic bit frogHits(input int carX, input int fx, input int fy);
        return (carX < fx + 32) && (fx < carX + 32) && (224 < fy + 32) && (fy < 224 + 32);
    endfunction

    task automatic modelStep();
        int period;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mMode[d] = 0; mX[d] = 0; mFrames[d] = 0; mFrozen[d] = 0; mColl[d] = 0;
            end else begin
                mColl[d] = 0;
                if (stop) begin
                    mMode[d] = 0;
                    mX[d] = 0;
                end else if (mMode[d] == 0) begin
                    if (start) begin
                        mMode[d] = 1;
                        mFrames[d] = 0;
                    end
                end else if (mMode[d] == 1) begin
                    if (tick) begin
                        period = 8 >> mLevel;
                        if (period < 1) period = 1;
                        if (frogHits(mX[d], int'(frogX), int'(frogY))) begin
                            mMode[d] = 2;
                            mFrozen[d] = 0;
                            mColl[d] = 1;
                        end else if (mFrames[d] + 1 >= period) begin
                            mX[d] = movedX(d, mX[d]);
                            mFrames[d] = 0;
                        end else begin
                            mFrames[d]++;
                        end
                    end
                end else if (tick) begin
                    mFrozen[d]++;
                    if (mFrozen[d] == 60) begin
                        mMode[d] = 1;
                        mX[d] = 0;
                        mFrames[d] = 0;
                    end
                end
            end
        end
        if (rst) mLevel = 0;
        else if (lvlUp && mLevel < 3) mLevel++;
    endtask

    always @(posedge clk) begin
        modelStep();
        #1;
        if (checking) begin
            checkOutput("lr_x", int'(lrX), mX[0]);
            checkOutput("lr_y", int'(lrY), 224);
            checkOutput("lr_coll", int'(lrColl), mColl[0]);
            checkOutput("lr_run", int'(lrRun), int'(mMode[0] == 1));
            checkOutput("lr_level", int'(lrLvl), mLevel);
            checkOutput("rl_x", int'(rlX), mX[1]);
            checkOutput("rl_y", int'(rlY), 224);
            checkOutput("rl_coll", int'(rlColl), mColl[1]);
            checkOutput("rl_run", int'(rlRun), int'(mMode[1] == 1));
            checkOutput("rl_level", int'(rlLvl), mLevel);
        end
    end

    task automatic applyStimulus(input bit r, input bit s, input bit p, input bit t, input bit l);
        @(negedge clk);
        rst = r; start = s; stop = p; tick = t; lvlUp = l;
        @(posedge clk);
        #2;
    endtask

    task automatic tickCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; tick = 0; lvlUp = 0;
        frogX = 10'd0; frogY = 10'd0;

        applyStimulus(1, 0, 0, 0, 0);
        checking = 1;
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("reset_x", int'(lrX), 0);
        checkOutput("reset_run", int'(lrRun), 0);
        checkOutput("reset_level", int'(lrLvl), 0);
        checkOutput("reset_coll", int'(lrColl), 0);

        applyStimulus(0, 1, 0, 0, 0);
        tickCycles(3);
        checkOutput("lvl0_3ticks_x", int'(lrX), 0);
        tickCycles(5);
        checkOutput("lvl0_8ticks_lr_x", int'(lrX), 4);
        checkOutput("lvl0_8ticks_rl_x", int'(rlX), 608);

        repeat (4) applyStimulus(0, 0, 0, 0, 1);
        checkOutput("level_saturate", int'(lrLvl), 3);
        tickCycles(150);
        checkOutput("lr_x_604", int'(lrX), 604);
        checkOutput("rl_x_8", int'(rlX), 8);
        tickCycles(1);
        checkOutput("lr_x_608", int'(lrX), 608);
        tickCycles(1);
        checkOutput("lr_wrap", int'(lrX), 0);
        checkOutput("rl_x_0", int'(rlX), 0);
        tickCycles(1);
        checkOutput("rl_wrap", int'(rlX), 608);

        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("stop_x", int'(lrX), 0);
        checkOutput("stop_run", int'(lrRun), 0);
        checkOutput("stop_keeps_level", int'(lrLvl), 3);

        applyStimulus(0, 1, 0, 0, 0);
        tickCycles(20);
        checkOutput("lr_x_80", int'(lrX), 80);
        checkOutput("rl_x_532", int'(rlX), 532);
        frogX = 10'd100; frogY = 10'd224;
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("hit_coll", int'(lrColl), 1);
        checkOutput("hit_x_frozen", int'(lrX), 80);
        checkOutput("hit_not_running", int'(lrRun), 0);
        checkOutput("rl_no_hit", int'(rlColl), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("hit_coll_one_cycle", int'(lrColl), 0);
        tickCycles(59);
        checkOutput("freeze_59_run", int'(lrRun), 0);
        checkOutput("freeze_59_x", int'(lrX), 80);
        tickCycles(1);
        checkOutput("respawn_run", int'(lrRun), 1);
        checkOutput("respawn_x", int'(lrX), 0);

        frogY = 10'd0;
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        frogX = 10'd32; frogY = 10'd224;
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("frog32_no_hit", int'(lrColl), 0);
        checkOutput("frog32_moved", int'(lrX), 4);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        frogX = 10'd31;
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("frog31_hit_lr", int'(lrColl), 1);
        checkOutput("frog31_hit_rl", int'(rlColl), 1);

        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst_hit_run", int'(lrRun), 0);
        checkOutput("rst_hit_x", int'(lrX), 0);
        checkOutput("rst_hit_level", int'(lrLvl), 0);
        checkOutput("rst_hit_coll", int'(lrColl), 0);

        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("stop_over_hit_coll", int'(lrColl), 0);
        checkOutput("stop_over_hit_run", int'(lrRun), 0);
        checkOutput("stop_over_hit_x", int'(lrX), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("stop_over_hit_coll_late", int'(rlColl), 0);

        frogY = 10'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                frogX = 10'($urandom_range(0, 639));
                frogY = 10'($urandom_range(180, 270));
            end
            applyStimulus($urandom_range(0, 999) == 0,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 149) == 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 299) == 0);
        end

        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
